lsu_handshake: RTL and testbench

LSU_HANDSHAKE -- requirements
Module: lsu_handshake

---
 rtl/lsu_handshake.sv | 257 +++++++++++++++++++++++++
 tb/tb_lsu_handshake.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_handshake.sv
// rtl/lsu_handshake.sv - single-outstanding load/store unit between a core request port and a memory port
//
// One access in flight at a time: a request is latched in IDLE, issued on the memory port
// in REQ, waits for read data in WAIT (loads only) and is presented on the response port
// in RESP until it is taken.
//
// Parameters
//   DATA_W        data/lane width in bits (32 or 64)
//   ADDR_W        byte-address width
//
// Build option
//   LSU_MISALIGN_TRAP_EN  defined:   misaligned requests skip memory and respond with resp_ale=1
//                         undefined: misaligned requests are aligned down to the access size
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op                     [1:0] size B/H/W/D, [2] unsigned load, [3] store
//   req_addr/req_wdata/req_rd  byte address, store data (lane 0 aligned), load destination tag
//   resp_valid/resp_ready      response handshake
//   resp_rdata/resp_rd/resp_ale formatted load data (0 for stores), tag, alignment error
//   mem_req/mem_gnt            memory request handshake
//   mem_we/mem_be/mem_addr/mem_wdata  write enable, byte enables, lane-aligned address, lane data
//   mem_rvalid/mem_rdata       memory read return
//   busy                       an access is in flight

module lsu_handshake #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [4:0]          req_rd,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [4:0]          resp_rd,
    output logic                resp_ale,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BW    = DATA_W / 8;
    localparam int OFF_W = $clog2(BW);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                store_q, store_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [4:0]          rd_q, rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BW-1:0]       mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_ale_q, resp_ale_d;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the incoming request, used on accept)
    // ------------------------------------------------------------------
    logic [1:0]          size_eff;
    logic [OFF_W-1:0]    req_off;
    logic [OFF_W-1:0]    align_mask;
    logic [OFF_W-1:0]    off_eff;
    logic                trap;
    logic [BW-1:0]       be_base;

    // A 32-bit lane has no doubleword; D degrades to W.
    assign size_eff = (DATA_W == 32 && req_op[1:0] == 2'd3) ? 2'd2 : req_op[1:0];
    assign req_off  = req_addr[OFF_W-1:0];

    always_comb begin
        align_mask = '0;
        be_base    = '0;
        case (size_eff)
            2'd0: begin
                align_mask = OFF_W'(0);
                be_base    = BW'(1);
            end
            2'd1: begin
                align_mask = OFF_W'(1);
                be_base    = BW'(3);
            end
            2'd2: begin
                align_mask = OFF_W'(3);
                be_base    = BW'(15);
            end
            default: begin
                align_mask = OFF_W'(7);
                be_base    = {BW{1'b1}};
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap    = |(req_off & align_mask);
    assign off_eff = req_off;
`else
    assign trap    = 1'b0;
    assign off_eff = req_off & ~align_mask;
`endif

    // ------------------------------------------------------------------
    // Load data formatting from the latched offset/size/sign mode
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rdata_sh;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;
    logic [DATA_W-1:0] load_fmt;

    assign rdata_sh = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size_q)
            2'd0: begin
                keep_mask = DATA_W'(32'h0000_00FF);
                sign_bit  = rdata_sh[7];
            end
            2'd1: begin
                keep_mask = DATA_W'(32'h0000_FFFF);
                sign_bit  = rdata_sh[15];
            end
            2'd2: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = rdata_sh[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = rdata_sh[DATA_W-1];
            end
        endcase
        if (uns_q) begin
            sign_bit = 1'b0;
        end
        load_fmt = (rdata_sh & keep_mask) | ({DATA_W{sign_bit}} & ~keep_mask);
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        store_d      = store_q;
        off_d        = off_q;
        rd_d         = rd_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_ale_d   = resp_ale_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d       = size_eff;
                    uns_d        = req_op[2];
                    store_d      = req_op[3];
                    off_d        = off_eff;
                    rd_d         = req_rd;
                    mem_addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_be_d     = be_base << off_eff;
                    mem_wdata_d  = req_wdata << {off_eff, 3'b000};
                    // Stores and trapped accesses respond with zero data.
                    resp_rdata_d = '0;
                    resp_ale_d   = trap;
                    state_d      = trap ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = store_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp_rdata_d = load_fmt;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            size_q       <= '0;
            uns_q        <= 1'b0;
            store_q      <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_ale_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            store_q      <= store_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_ale_q   <= resp_ale_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_req    = (state_q == REQ);
    assign mem_we     = (state_q == REQ) && store_q;
    assign mem_be     = (state_q == REQ) ? mem_be_q : '0;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = rd_q;
    assign resp_ale   = resp_ale_q;

endmodule

// File: tb/tb_lsu_handshake.sv
// tb/tb_lsu_handshake.sv - directed self-checking bench for lsu_handshake (32-bit and 64-bit lanes)

module tb_lsu_handshake;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 32-bit instance
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_ale;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  req_rd, resp_rd;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid, busy;
    logic [3:0]  mem_be;

    // 64-bit instance
    logic        req_valid_w, req_ready_w, resp_valid_w, resp_ready_w, resp_ale_w;
    logic [3:0]  req_op_w;
    logic [31:0] req_addr_w, mem_addr_w;
    logic [63:0] req_wdata_w, resp_rdata_w, mem_wdata_w, mem_rdata_w;
    logic [4:0]  req_rd_w, resp_rd_w;
    logic        mem_req_w, mem_gnt_w, mem_we_w, mem_rvalid_w, busy_w;
    logic [7:0]  mem_be_w;

    lsu_handshake #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_ale(resp_ale),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    lsu_handshake #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_w), .req_ready(req_ready_w), .req_op(req_op_w),
        .req_addr(req_addr_w), .req_wdata(req_wdata_w), .req_rd(req_rd_w),
        .resp_valid(resp_valid_w), .resp_ready(resp_ready_w), .resp_rdata(resp_rdata_w),
        .resp_rd(resp_rd_w), .resp_ale(resp_ale_w),
        .mem_req(mem_req_w), .mem_gnt(mem_gnt_w), .mem_we(mem_we_w), .mem_be(mem_be_w),
        .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
        .mem_rvalid(mem_rvalid_w), .mem_rdata(mem_rdata_w), .busy(busy_w)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        resp_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        req_valid_w = 0; req_op_w = 0; req_addr_w = 0; req_wdata_w = 0; req_rd_w = 0;
        resp_ready_w = 0; mem_gnt_w = 0; mem_rvalid_w = 0; mem_rdata_w = 0;

        // ---------------- reset state ----------------
        step(2);
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_ale", resp_ale, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_rd", resp_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // ---------------- st.h 0x102 <- 0xABCD ----------------
        req_valid = 1; req_op = 4'b1001; req_addr = 32'h102; req_wdata = 32'h0000_ABCD; req_rd = 5'd7;
        step();                                  // cycle T+1
        req_valid = 0;
        chk("sth_mem_req", mem_req, 1);
        chk("sth_mem_we", mem_we, 1);
        chk("sth_mem_addr", mem_addr, 32'h100);
        chk("sth_mem_be", mem_be, 4'hC);
        chk("sth_mem_wdata", mem_wdata, 32'hABCD_0000);
        chk("sth_req_ready", req_ready, 0);
        chk("sth_busy", busy, 1);
        chk("sth_resp_valid_t1", resp_valid, 0);
        mem_gnt = 1;
        step();                                  // cycle T+2
        mem_gnt = 0;
        chk("sth_resp_valid_t2", resp_valid, 1);
        chk("sth_resp_rdata", resp_rdata, 0);
        chk("sth_resp_rd", resp_rd, 7);
        chk("sth_resp_ale", resp_ale, 0);
        chk("sth_mem_req_off", mem_req, 0);
        resp_ready = 1;
        step();
        resp_ready = 0;
        chk("sth_idle_resp_valid", resp_valid, 0);
        chk("sth_idle_req_ready", req_ready, 1);

        // ---------------- ld.b 0x1C000003, rdata 0x80FFFF00 ----------------
        req_valid = 1; req_op = 4'b0000; req_addr = 32'h1C00_0003; req_rd = 5'd3;
        step();                                  // T+1
        req_valid = 0;
        chk("ldb_mem_req", mem_req, 1);
        chk("ldb_mem_we", mem_we, 0);
        chk("ldb_mem_addr", mem_addr, 32'h1C00_0000);
        chk("ldb_mem_be", mem_be, 4'h8);
        mem_gnt = 1;
        step();                                  // T+2 (WAIT)
        mem_gnt = 0;
        chk("ldb_wait_resp_valid", resp_valid, 0);
        chk("ldb_wait_mem_req", mem_req, 0);
        mem_rvalid = 1; mem_rdata = 32'h80FF_FF00;
        step();                                  // T+3
        mem_rvalid = 0; mem_rdata = 0;
        chk("ldb_resp_valid_t3", resp_valid, 1);
        chk("ldb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
        chk("ldb_resp_rd", resp_rd, 3);
        // Request presented while busy must be ignored.
        req_valid = 1; req_op = 4'b1010; req_addr = 32'h40; req_rd = 5'd21;
        step();
        chk("busy_hold_resp_valid", resp_valid, 1);
        chk("busy_hold_resp_rd", resp_rd, 3);
        chk("busy_hold_req_ready", req_ready, 0);
        req_valid = 0; resp_ready = 1;
        step();
        resp_ready = 0;
        chk("busy_drop_req_ready", req_ready, 1);
        chk("busy_drop_mem_req", mem_req, 0);
        // Stray grant and read return in IDLE are ignored.
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        chk("stray_req_ready", req_ready, 1);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_resp_rdata", resp_rdata, 32'hFFFF_FF80);

        // ---------------- ld.hu 0x2, grant held off 3, resp_ready low 2 ----------------
        req_valid = 1; req_op = 4'b0101; req_addr = 32'h2; req_rd = 5'd9;
        step();
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_mem_req", mem_req, 1);
            chk("stall_mem_addr", mem_addr, 32'h0);
            chk("stall_mem_be", mem_be, 4'hC);
            chk("stall_req_ready", req_ready, 0);
            step();
        end
        chk("stall_mem_req_gnt", mem_req, 1);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = 32'h8001_1234;
        step();
        mem_rvalid = 0; mem_rdata = 0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_rdata", resp_rdata, 32'h0000_8001);
            chk("bp_req_ready", req_ready, 0);
            step();
        end
        chk("bp_resp_valid_last", resp_valid, 1);
        resp_ready = 1;
        step();
        resp_ready = 0;
        chk("bp_idle", req_ready, 1);

        // ---------------- ld.w 0x102 (misaligned) ----------------
        req_valid = 1; req_op = 4'b0010; req_addr = 32'h102; req_rd = 5'd1;
        step();
        req_valid = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_mem_req", mem_req, 0);
        chk("mis_resp_valid", resp_valid, 1);
        chk("mis_resp_ale", resp_ale, 1);
        chk("mis_resp_rdata", resp_rdata, 0);
`else
        chk("mis_mem_req", mem_req, 1);
        chk("mis_mem_addr", mem_addr, 32'h100);
        chk("mis_mem_be", mem_be, 4'hF);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = 32'h1122_3344;
        step();
        mem_rvalid = 0; mem_rdata = 0;
        chk("mis_resp_valid", resp_valid, 1);
        chk("mis_resp_rdata", resp_rdata, 32'h1122_3344);
        chk("mis_resp_ale", resp_ale, 0);
`endif
        resp_ready = 1;
        step();
        resp_ready = 0;
        chk("mis_idle", req_ready, 1);

        // ---------------- reset while in WAIT, then late rvalid ----------------
        req_valid = 1; req_op = 4'b0010; req_addr = 32'h200; req_rd = 5'd2;
        step();
        req_valid = 0; mem_gnt = 1;
        step();
        mem_gnt = 0;
        chk("rw_wait_busy", busy, 1);
        chk("rw_wait_resp_valid", resp_valid, 0);
        reset = 1;
        step();
        reset = 0;
        chk("rw_req_ready", req_ready, 1);
        chk("rw_busy", busy, 0);
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 0; mem_rdata = 0;
        chk("rw_late_resp_valid", resp_valid, 0);
        chk("rw_late_req_ready", req_ready, 1);
        chk("rw_late_resp_rdata", resp_rdata, 0);
        step();
        chk("rw_settle_resp_valid", resp_valid, 0);

        // ---------------- 64-bit: ld.hu 0x6 ----------------
        req_valid_w = 1; req_op_w = 4'b0101; req_addr_w = 32'h6; req_rd_w = 5'd12;
        step();
        req_valid_w = 0;
        chk("w_ldhu_mem_req", mem_req_w, 1);
        chk("w_ldhu_mem_addr", mem_addr_w, 32'h0);
        chk("w_ldhu_mem_be", mem_be_w, 8'hC0);
        mem_gnt_w = 1;
        step();
        mem_gnt_w = 0;
        mem_rvalid_w = 1; mem_rdata_w = 64'hBEEF_0000_0000_0000;
        step();
        mem_rvalid_w = 0; mem_rdata_w = 0;
        chk("w_ldhu_resp_valid", resp_valid_w, 1);
        chk("w_ldhu_resp_rdata", resp_rdata_w, 64'h0000_0000_0000_BEEF);
        chk("w_ldhu_resp_rd", resp_rd_w, 12);
        resp_ready_w = 1;
        step();
        resp_ready_w = 0;

        // ---------------- 64-bit: ld.w 0x4 (sign-extended) ----------------
        req_valid_w = 1; req_op_w = 4'b0010; req_addr_w = 32'h4; req_rd_w = 5'd13;
        step();
        req_valid_w = 0;
        chk("w_ldw_mem_be", mem_be_w, 8'hF0);
        mem_gnt_w = 1;
        step();
        mem_gnt_w = 0;
        mem_rvalid_w = 1; mem_rdata_w = 64'h8000_0001_0000_0000;
        step();
        mem_rvalid_w = 0; mem_rdata_w = 0;
        chk("w_ldw_resp_rdata", resp_rdata_w, 64'hFFFF_FFFF_8000_0001);
        resp_ready_w = 1;
        step();
        resp_ready_w = 0;
        chk("w_ldw_idle", req_ready_w, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
